// File: rtl/wb_regfile_pkg.sv
// Shared MEM/WB writeback constants and the register-address type.
// Also used by the MEM/WB pipeline register and the forwarding unit.
package wb_regfile_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CNT_W = 32;

    typedef logic [AW-1:0] reg_addr_t;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_core.sv
// Integer register storage: async-cleared array, one write port, two raw read
// ports. Entry 0 is not stored; addresses 0 and >= NREGS read back as zero.
// Ports:
//   clk, rst_n        clock, asynchronous active-low clear
//   we, waddr, wdata  write port (commits on posedge)
//   raddr1/2, rdata1/2 combinational raw read ports (no bypass)
module wb_regfile_core #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [1:NREGS-1];

    // Storage update; unmatched addresses (0, out of range) fall through untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int i = 1; i < NREGS; i++) begin
                if (waddr == AW'(i)) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Raw read muxes
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (raddr1 == AW'(i)) rdata1 = regs[i];
            if (raddr2 == AW'(i)) rdata2 = regs[i];
        end
    end

endmodule : wb_regfile_core

// File: rtl/wb_regfile.sv
// Writeback stage: selects memory vs ALU data, commits it to the register
// file, serves two ID read ports with write-through bypass, exports the
// writeback value for forwarding and counts retired register writes.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   RegWrite_i, MemtoReg_i, addr_i, Read_data_i, instr_11_i   MEM/WB inputs
//   rs1/rs2_addr_i, rs1/rs2_data_o   ID read ports (combinational)
//   wb_data_o, wb_en_o, wb_rd_o      forwarding outputs (combinational)
//   wr_count_o                       committed-write counter (registered)
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned XLEN   = wb_regfile_pkg::XLEN,
    parameter int unsigned NREGS  = wb_regfile_pkg::NREGS,
    parameter int unsigned AW     = wb_regfile_pkg::AW,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned CNT_W  = wb_regfile_pkg::CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             RegWrite_i,
    input  logic             MemtoReg_i,
    input  logic [XLEN-1:0]  addr_i,
    input  logic [XLEN-1:0]  Read_data_i,
    input  logic [AW-1:0]    instr_11_i,
    input  logic [AW-1:0]    rs1_addr_i,
    input  logic [AW-1:0]    rs2_addr_i,
    output logic [XLEN-1:0]  rs1_data_o,
    output logic [XLEN-1:0]  rs2_data_o,
    output logic [XLEN-1:0]  wb_data_o,
    output logic             wb_en_o,
    output logic [AW-1:0]    wb_rd_o,
    output logic [CNT_W-1:0] wr_count_o
);

    logic            rd_in_range;
    logic            commit;
    logic [XLEN-1:0] raw1;
    logic [XLEN-1:0] raw2;

    // Writeback select and forwarding qualifiers
    always_comb begin
        wb_data_o   = MemtoReg_i ? Read_data_i : addr_i;
        wb_en_o     = RegWrite_i && (instr_11_i != '0);
        wb_rd_o     = instr_11_i;
        rd_in_range = 32'(instr_11_i) < NREGS;
        commit      = wb_en_o && rd_in_range;
    end

    wb_regfile_core #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_core (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .we     (commit),
        .waddr  (instr_11_i),
        .wdata  (wb_data_o),
        .raddr1 (rs1_addr_i),
        .raddr2 (rs2_addr_i),
        .rdata1 (raw1),
        .rdata2 (raw2)
    );

    // Read ports: x0 forced to zero; bypass only for a write that will really
    // commit, so out-of-range addresses keep reading zero
    always_comb begin
        rs1_data_o = raw1;
        rs2_data_o = raw2;
        if (BYPASS != 0 && commit && rs1_addr_i == instr_11_i) rs1_data_o = wb_data_o;
        if (BYPASS != 0 && commit && rs2_addr_i == instr_11_i) rs2_data_o = wb_data_o;
        if (rs1_addr_i == '0) rs1_data_o = '0;
        if (rs2_addr_i == '0) rs2_data_o = '0;
    end

    // Retired-write counter, wraps modulo 2^CNT_W
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_count_o <= '0;
        end else if (commit) begin
            wr_count_o <= wr_count_o + CNT_W'(1);
        end
    end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile. Instance A uses the default build; instance B
// shares all inputs but has BYPASS=0, NREGS=16 and a 3-bit counter.
module tb_wb_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RegWrite_i;
    logic        MemtoReg_i;
    logic [31:0] addr_i;
    logic [31:0] Read_data_i;
    logic [4:0]  instr_11_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;

    logic [31:0] a_rs1, a_rs2, a_wbd, a_cnt;
    logic        a_wben;
    logic [4:0]  a_wbrd;
    logic [31:0] b_rs1, b_rs2, b_wbd;
    logic        b_wben;
    logic [4:0]  b_wbrd;
    logic [2:0]  b_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk_i = ~clk_i;

    wb_regfile dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .addr_i(addr_i), .Read_data_i(Read_data_i), .instr_11_i(instr_11_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_o(a_rs1), .rs2_data_o(a_rs2), .wb_data_o(a_wbd),
        .wb_en_o(a_wben), .wb_rd_o(a_wbrd), .wr_count_o(a_cnt)
    );

    wb_regfile #(.BYPASS(0), .NREGS(16), .CNT_W(3)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .addr_i(addr_i), .Read_data_i(Read_data_i), .instr_11_i(instr_11_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_o(b_rs1), .rs2_data_o(b_rs2), .wb_data_o(b_wbd),
        .wb_en_o(b_wben), .wb_rd_o(b_wbrd), .wr_count_o(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive all MEM/WB and read-port inputs, then let combinational logic settle
    task automatic drive(input logic we, input logic m2r, input logic [31:0] alu,
                         input logic [31:0] rdat, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2);
        RegWrite_i  = we;
        MemtoReg_i  = m2r;
        addr_i      = alu;
        Read_data_i = rdat;
        instr_11_i  = rd;
        rs1_addr_i  = r1;
        rs2_addr_i  = r2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_4444, 32'h0, 5'd4, 5'd0, 5'd0);
        tick();
        tick();

        // 1. reset: writes suppressed, all registers zero, counters zero
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(32 - i));
            chk($sformatf("rst_a_rs1_x%0d", i), a_rs1, 32'h0);
            chk($sformatf("rst_b_rs2_x%0d", 32 - i), b_rs2, 32'h0);
        end
        chk("rst_a_cnt", a_cnt, 32'd0);
        chk("rst_b_cnt", 32'(b_cnt), 32'd0);
        rst_i = 1'b1;

        // 2. ALU writeback to x5
        drive(1'b1, 1'b0, 32'h0000_1234, 32'hFFFF_0000, 5'd5, 5'd5, 5'd0);
        chk("alu_wbd", a_wbd, 32'h0000_1234);
        chk("alu_wben", 32'(a_wben), 32'd1);
        chk("alu_wbrd", 32'(a_wbrd), 32'd5);
        chk("alu_a_byp", a_rs1, 32'h0000_1234);
        chk("alu_b_nobyp", b_rs1, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        chk("alu_a_x5", a_rs1, 32'h0000_1234);
        chk("alu_b_x5", b_rs1, 32'h0000_1234);
        chk("alu_a_cnt", a_cnt, 32'd1);
        chk("alu_b_cnt", 32'(b_cnt), 32'd1);

        // 3. load writeback to x7
        drive(1'b1, 1'b1, 32'h1111_1111, 32'hDEAD_BEEF, 5'd7, 5'd0, 5'd0);
        chk("ld_wbd", a_wbd, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7);
        chk("ld_a_x7", a_rs2, 32'hDEAD_BEEF);
        chk("ld_b_x7", b_rs2, 32'hDEAD_BEEF);
        chk("ld_a_x5", a_rs1, 32'h0000_1234);
        chk("ld_a_cnt", a_cnt, 32'd2);

        // 4. both ports bypass x9 in the same cycle
        drive(1'b1, 1'b0, 32'hA5A5_A5A5, 32'h0, 5'd9, 5'd9, 5'd9);
        chk("byp_a_rs1", a_rs1, 32'hA5A5_A5A5);
        chk("byp_a_rs2", a_rs2, 32'hA5A5_A5A5);
        chk("byp_b_rs1", b_rs1, 32'h0);
        chk("byp_b_rs2", b_rs2, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
        chk("byp_b_x9", b_rs1, 32'hA5A5_A5A5);
        chk("byp_a_x9", a_rs2, 32'hA5A5_A5A5);

        // back-to-back writes to x9: last wins, bypass shows the newest value
        drive(1'b1, 1'b0, 32'h0000_0001, 32'h0, 5'd9, 5'd9, 5'd0);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0002, 32'h0, 5'd9, 5'd9, 5'd0);
        chk("b2b_a_byp", a_rs1, 32'h0000_0002);
        chk("b2b_b_old", b_rs1, 32'h0000_0001);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
        chk("b2b_a_x9", a_rs1, 32'h0000_0002);
        chk("b2b_b_x9", b_rs1, 32'h0000_0002);
        chk("b2b_a_cnt", a_cnt, 32'd5);

        // 5. x0 writes are discarded and not counted
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
        chk("x0_wben", 32'(a_wben), 32'd0);
        chk("x0_a_rs1_now", a_rs1, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        chk("x0_a_rs1_after", a_rs1, 32'h0);
        chk("x0_a_cnt", a_cnt, 32'd5);
        chk("x0_b_cnt", 32'(b_cnt), 32'd5);

        // rd beyond NREGS in build B: ignored there, normal write in build A
        drive(1'b1, 1'b0, 32'h0000_0055, 32'h0, 5'd20, 5'd20, 5'd0);
        chk("oor_b_wben", 32'(b_wben), 32'd1);
        chk("oor_a_byp", a_rs1, 32'h0000_0055);
        chk("oor_b_rd", b_rs1, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd20, 5'd0);
        chk("oor_a_x20", a_rs1, 32'h0000_0055);
        chk("oor_b_x20", b_rs1, 32'h0);
        chk("oor_a_cnt", a_cnt, 32'd6);
        chk("oor_b_cnt", 32'(b_cnt), 32'd5);

        // counter wrap: B reaches 7 (all ones), the next write wraps to 0
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd10, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0011, 32'h0, 5'd10, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd0);
        chk("wrap_b_full", 32'(b_cnt), 32'd7);
        drive(1'b1, 1'b0, 32'h0000_0012, 32'h0, 5'd11, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd11, 5'd10);
        chk("wrap_b_cnt", 32'(b_cnt), 32'd0);
        chk("wrap_a_cnt", a_cnt, 32'd9);
        chk("wrap_a_x11", a_rs1, 32'h0000_0012);
        chk("wrap_b_x10", b_rs2, 32'h0000_0011);

        // 6. async reset between edges while a write to x3 is pending
        drive(1'b1, 1'b0, 32'h0000_0033, 32'h0, 5'd3, 5'd3, 5'd5);
        chk("ar_pre_x5", a_rs2, 32'h0000_1234);
        #2;
        rst_i = 1'b0;
        #1;
        chk("ar_a_x5_now", a_rs2, 32'h0);
        chk("ar_b_x5_now", b_rs2, 32'h0);
        chk("ar_a_cnt_now", a_cnt, 32'd0);
        chk("ar_b_cnt_now", 32'(b_cnt), 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd7);
        chk("ar_a_x3", a_rs1, 32'h0);
        chk("ar_a_x7", a_rs2, 32'h0);
        rst_i = 1'b1;
        drive(1'b1, 1'b1, 32'h0, 32'h0000_0077, 5'd3, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
        chk("ar_post_x3", a_rs1, 32'h0000_0077);
        chk("ar_post_b_x3", b_rs1, 32'h0000_0077);
        chk("ar_post_cnt", a_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_wb_regfile
